bullet_controller: RTL and testbench

- Upstream stage of color_mapper. Generates the player bullet's position and active flag: bullet_in, bulletX, bulletY.
- Spawns a bullet above the player on a fire request and moves it up a fixed step per video frame.
- Kills the bullet when it leaves the top of the screen or on a hit from collision logic, then enforces a cooldown before the next shot.

---
 rtl/bullet_controller_pkg.sv | 15 +
 rtl/bullet_controller_if.sv | 14 +
 rtl/bullet_controller_frame_tick_gen.sv | 24 ++
 rtl/bullet_controller.sv | 119 +++++++++++
 tb/tb_bullet_controller.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/bullet_controller_pkg.sv
// Shared screen geometry and types for the space invaders video pipeline.
// Imported by the bullet controller, its interface, and color_mapper.
package space_invaders_pkg;
   localparam int SCREEN_W     = 640;
   localparam int SCREEN_H     = 480;
   localparam int PLAYER_Y_DEF = 150;

   typedef logic [9:0] coord_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FLY  = 2'd1,
      COOL = 2'd2
   } bullet_state_t;
endpackage

// File: rtl/bullet_controller_if.sv
// Bullet controller signal bundle.
// The master side is the controller; the slave side is the game/video logic around it.
interface bullet_controller_if;
   logic                        fire;
   space_invaders_pkg::coord_t  playerX;
   logic                        hit;
   logic                        bullet_in;
   space_invaders_pkg::coord_t  bulletX;
   space_invaders_pkg::coord_t  bulletY;
   logic                        busy;

   modport master (input fire, playerX, hit, output bullet_in, bulletX, bulletY, busy);
   modport slave  (output fire, playerX, hit, input bullet_in, bulletX, bulletY, busy);
endinterface

// File: rtl/bullet_controller_frame_tick_gen.sv
// Brings the asynchronous frame_clk strobe into the Clk domain.
// Output is a registered one-Clk pulse per frame_clk rise, three Clk edges after the rise.
module frame_tick_gen (
   input  logic Clk,
   input  logic rst_n,
   input  logic frame_clk,
   output logic frame_tick
);
   logic sync_1, sync_2, sync_3;

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1     <= 1'b0;
         sync_2     <= 1'b0;
         sync_3     <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         sync_1     <= frame_clk;
         sync_2     <= sync_1;
         sync_3     <= sync_2;
         frame_tick <= sync_2 & ~sync_3;
      end
   end
endmodule

// File: rtl/bullet_controller.sv
// Player bullet controller: spawns, moves and kills the bullet, then cools down.
// Define BULLET_FIRE_EDGE_EN to require fire to be released between shots.
//
// state | meaning
// IDLE  | no bullet; spawn on frame tick with fire
// FLY   | bullet active, moves up BULLET_STEP per frame tick
// COOL  | bullet dead, counting frame ticks before next shot
module bullet_controller
   import space_invaders_pkg::*;
#(
   parameter int PLAYER_Y        = PLAYER_Y_DEF,
   parameter int BULLET_LEN      = 4,
   parameter int BULLET_STEP     = 4,
   parameter int COOLDOWN_FRAMES = 8
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               frame_clk,
   bullet_controller_if.master bif
);
   localparam coord_t     SPAWN_Y   = coord_t'(PLAYER_Y - BULLET_LEN);
   localparam coord_t     STEP      = coord_t'(BULLET_STEP);
   localparam logic [7:0] COOL_INIT = 8'(COOLDOWN_FRAMES);

   logic          rst_meta, rst_n;
   logic          frame_tick;
   bullet_state_t state, state_nxt;
   logic          bullet_in_q, bullet_in_nxt;
   coord_t        x_q, x_nxt, y_q, y_nxt;
   logic [7:0]    count, count_nxt;
   logic          busy_q;
   logic          armed, spawn, kill;

   // Asserts immediately, releases on Clk so all state leaves reset on the same edge
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         rst_meta <= 1'b0;
         rst_n    <= 1'b0;
      end else begin
         rst_meta <= 1'b1;
         rst_n    <= rst_meta;
      end
   end

   frame_tick_gen u_frame_tick_gen (
      .Clk        (Clk),
      .rst_n      (rst_n),
      .frame_clk  (frame_clk),
      .frame_tick (frame_tick)
   );

`ifdef BULLET_FIRE_EDGE_EN
   logic arm;
   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n)                    arm <= 1'b1;
      else if (spawn)                arm <= 1'b0;
      else if (frame_tick && !bif.fire) arm <= 1'b1;
   end
   assign armed = arm;
`else
   assign armed = 1'b1;
`endif

   assign spawn = (state == IDLE) && frame_tick && bif.fire && armed;
   // hit outranks a same-cycle frame tick, so the bullet dies without stepping
   assign kill  = (state == FLY) && (bif.hit || (frame_tick && (y_q < STEP)));

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         bullet_in_q <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         count       <= '0;
         busy_q      <= 1'b0;
      end else begin
         state       <= state_nxt;
         bullet_in_q <= bullet_in_nxt;
         x_q         <= x_nxt;
         y_q         <= y_nxt;
         count       <= count_nxt;
         busy_q      <= (state_nxt != IDLE);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (spawn) state_nxt = FLY;
         FLY:     if (kill) state_nxt = (COOLDOWN_FRAMES == 0) ? IDLE : COOL;
         COOL:    if (frame_tick && (count == 8'd1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bullet_in_nxt = bullet_in_q;
      x_nxt         = x_q;
      y_nxt         = y_q;
      count_nxt     = count;
      if (spawn) begin
         bullet_in_nxt = 1'b1;
         x_nxt         = bif.playerX;
         y_nxt         = SPAWN_Y;
      end else if (kill) begin
         bullet_in_nxt = 1'b0;
         count_nxt     = COOL_INIT;
      end else if ((state == FLY) && frame_tick) begin
         y_nxt = y_q - STEP;
      end else if ((state == COOL) && frame_tick) begin
         count_nxt = count - 8'd1;
      end
   end

   assign bif.bullet_in = bullet_in_q;
   assign bif.bulletX   = x_q;
   assign bif.bulletY   = y_q;
   assign bif.busy      = busy_q;
endmodule

// File: tb/tb_bullet_controller.sv
// Scoreboard bench for bullet_controller: a per-tick reference model pushes expected
// outputs when each frame_clk rise is driven; they are popped and compared four Clk edges later.
module tb_bullet_controller;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic frame_clk = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   typedef struct {
      logic       act;
      logic [9:0] x;
      logic [9:0] y;
      logic       busy;
   } exp_t;
   exp_t sb[$];

   int         m_state;
   logic       m_in;
   logic [9:0] m_x, m_y;
   int         m_cnt;
   logic       m_arm;

   bullet_controller_if bif ();

   bullet_controller dut (
      .Clk       (clk),
      .Reset     (reset),
      .frame_clk (frame_clk),
      .bif       (bif)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_in = 1'b0; m_x = '0; m_y = '0; m_cnt = 0; m_arm = 1'b1;
   endtask

   task automatic model_step(input logic hit_on);
      case (m_state)
         0: if (bif.fire && m_arm) begin
               m_state = 1; m_in = 1'b1; m_x = bif.playerX; m_y = 10'd146;
`ifdef BULLET_FIRE_EDGE_EN
               m_arm = 1'b0;
`endif
            end
         1: if (hit_on || m_y < 10'd4) begin
               m_state = 2; m_in = 1'b0; m_cnt = 8;
            end else begin
               m_y = m_y - 10'd4;
            end
         default: begin
               m_cnt--;
               if (m_cnt == 0) m_state = 0;
            end
      endcase
`ifdef BULLET_FIRE_EDGE_EN
      if (!bif.fire) m_arm = 1'b1;
`endif
   endtask

   task automatic compare_pop(input string tag);
      exp_t e;
      check({tag, "_sb_size"}, sb.size(), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, "_bullet_in"}, bif.bullet_in, e.act);
         check({tag, "_bulletX"},   bif.bulletX,   e.x);
         check({tag, "_bulletY"},   bif.bulletY,   e.y);
         check({tag, "_busy"},      bif.busy,      e.busy);
      end
   endtask

   // One frame_clk rise; hit_on asserts hit in the cycle the controller sees the tick
   task automatic frame_tick(input string tag, input logic hit_on);
      exp_t pre;
      @(negedge clk);
      frame_clk = 1'b1;
      pre = '{m_in, m_x, m_y, (m_state != 0)};
      model_step(hit_on);
      sb.push_back('{m_in, m_x, m_y, (m_state != 0)});
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_early_in"}, bif.bullet_in, pre.act);
      check({tag, "_early_y"},  bif.bulletY,   pre.y);
      if (hit_on) bif.hit = 1'b1;
      @(posedge clk);
      #1;
      bif.hit = 1'b0;
      compare_pop(tag);
      @(negedge clk);
      frame_clk = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   initial begin
      bif.fire = 1'b0; bif.playerX = '0; bif.hit = 1'b0;
      model_reset();
      #3 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_bullet_in", bif.bullet_in, 0);
      check("rst_bulletX",   bif.bulletX,   0);
      check("rst_bulletY",   bif.bulletY,   0);
      check("rst_busy",      bif.busy,      0);
      @(negedge clk) reset = 1'b1;
      repeat (5) @(posedge clk);

      // spawn
      bif.playerX = 10'd320; bif.fire = 1'b1;
      frame_tick("spawn", 1'b0);
      check("spawn_y", bif.bulletY, 146);

      // flight with player sweeping 320 -> 400, then top exit
      for (int i = 1; i <= 36; i++) begin
         bif.playerX = 10'(320 + (i * 80) / 36);
         frame_tick("fly", 1'b0);
      end
      check("top_y", bif.bulletY, 2);
      check("top_x", bif.bulletX, 320);
      frame_tick("exit", 1'b0);
      check("exit_in", bif.bullet_in, 0);
      check("exit_y",  bif.bulletY,   2);
      check("exit_busy", bif.busy,    1);

      // cooldown with fire held; hit during COOL is ignored
      bif.playerX = 10'd200;
      for (int i = 1; i <= 8; i++) frame_tick("cool", (i == 3));
      check("cool_done_busy", bif.busy, 0);
      frame_tick("respawn", 1'b0);
`ifdef BULLET_FIRE_EDGE_EN
      check("respawn_in", bif.bullet_in, 0);
`else
      check("respawn_in", bif.bullet_in, 1);
`endif
      bif.fire = 1'b0;
      frame_tick("release", 1'b0);
      bif.fire = 1'b1; bif.playerX = 10'd450;
      frame_tick("refire", 1'b0);
      check("refire_in", bif.bullet_in, 1);

      // hit priority over a same-cycle tick
      for (int i = 0; i < 40 && m_y > 10'd102; i++) frame_tick("approach", 1'b0);
      begin
         logic [9:0] y_before;
         y_before = m_y;
         frame_tick("hit", 1'b1);
         check("hit_y_held", bif.bulletY, 32'(y_before));
         check("hit_in", bif.bullet_in, 0);
      end
      bif.fire = 1'b0;
      for (int i = 1; i <= 8; i++) frame_tick("cool2", 1'b0);

      // reset mid-flight
      bif.fire = 1'b1; bif.playerX = 10'd60;
      frame_tick("spawn2", 1'b0);
      frame_tick("fly2", 1'b0);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("midrst_bullet_in", bif.bullet_in, 0);
      check("midrst_bulletX",   bif.bulletX,   0);
      check("midrst_bulletY",   bif.bulletY,   0);
      check("midrst_busy",      bif.busy,      0);
      model_reset();
      bif.fire = 1'b0;
      @(negedge clk) reset = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("post_rst_in", bif.bullet_in, 0);
      frame_tick("post_rst_nofire", 1'b0);
      bif.fire = 1'b1; bif.playerX = 10'd77;
      frame_tick("post_rst_fire", 1'b0);
      check("post_rst_x", bif.bulletX, 77);

      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
